// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage and the IF/ID boundary.
// Package if_pkg is also imported by decode for the if_id_t layout.
package if_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] pc_four;
    logic            valid;
  } if_id_t;

  // Instruction addresses are word aligned; the low two target bits are discarded.
  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// Counter outputs exist only when IF_PERF_CNT_EN is defined.
interface if_fetch_stage_if;

  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_bubble_cnt;
`endif

  // The fetch stage side.
  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_data,
    output o_imem_addr, o_instr, o_pc, o_pc_four, o_valid
`ifdef IF_PERF_CNT_EN
    , output o_fetch_cnt, o_bubble_cnt
`endif
  );

  // Memory / decode / hazard-unit side.
  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_data,
    input  o_imem_addr, o_instr, o_pc, o_pc_four, o_valid
`ifdef IF_PERF_CNT_EN
    , input o_fetch_cnt, o_bubble_cnt
`endif
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush > hold > fill-or-bubble.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_flush,
  input  logic           i_hold,
  input  logic           i_fill,
  input  if_pkg::if_id_t i_d,
  output if_pkg::if_id_t o_q
);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_q.instr   <= NOP;
      o_q.pc      <= RESET_PC;
      o_q.pc_four <= RESET_PC + 32'd4;
      o_q.valid   <= 1'b0;
    end else if (i_flush) begin
      // PC fields keep their last value so a squashed slot never toggles them.
      o_q.instr <= NOP;
      o_q.valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_fill) begin
        o_q <= i_d;
      end else begin
        o_q.instr <= NOP;
        o_q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I fetch front end: PC ownership, one-ahead prefetch into a 1-cycle i_mem, IF/ID capture.
// Optional IF_PERF_CNT_EN adds fetched-instruction and bubble counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input logic               i_clk,
  input logic               i_reset,
  if_fetch_stage_if.master  bus
);

  import if_pkg::*;

  logic [ILEN-1:0] fetch_pc_q;
  logic [ILEN-1:0] fetch_pc_inc;
  logic [ILEN-1:0] imem_addr;
  logic            primed_q;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  // Re-present the same address when unprimed or stalled so the word survives the hold.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    imem_addr = fetch_pc_inc;
    if (bus.i_redirect) begin
      imem_addr = align_pc(bus.i_redirect_pc);
    end else if (!primed_q || bus.i_stall) begin
      imem_addr = fetch_pc_q;
    end
  end

  assign bus.o_imem_addr = imem_addr;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fetch_pc_q <= RESET_VEC;
      primed_q   <= 1'b0;
    end else begin
      fetch_pc_q <= imem_addr;
      primed_q   <= 1'b1;
    end
  end

  assign if_id_d = '{
    instr:   bus.i_imem_data,
    pc:      fetch_pc_q,
    pc_four: fetch_pc_inc,
    valid:   1'b1
  };

  if_id_reg #(
    .RESET_PC (RESET_VEC),
    .NOP      (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (bus.i_redirect),
    .i_hold  (bus.i_stall),
    .i_fill  (primed_q),
    .i_d     (if_id_d),
    .o_q     (if_id_q)
  );

  assign bus.o_instr   = if_id_q.instr;
  assign bus.o_pc      = if_id_q.pc;
  assign bus.o_pc_four = if_id_q.pc_four;
  assign bus.o_valid   = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // A redirect overrides stall, so its flush bubble is latched and counted.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.i_redirect || !bus.i_stall) begin
      if (bus.i_redirect || !primed_q) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_fetch_cnt  = fetch_cnt_q;
  assign bus.o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch front end of the pipelined RV32I core.
- Owns the PC and drives the address of the synchronous instruction memory (`i_mem`, 1-cycle registered read) one cycle ahead (pre-fetch).
- Captures the returned word into the IF/ID pipeline register.
- Handles decode-side stall (hold) and execute-side redirect (flush plus new target), inserting NOP bubbles where required.

Parameters:
- RESET_VEC, 32'h0000_0000, first instruction address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- i_clk  in  1  core clock; all state on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_stall  in  1  hold IF/ID and PC (load-use hazard from decode).
- i_redirect  in  1  taken branch/jump; flush and refetch.
- i_redirect_pc  in  32  redirect target; low 2 bits ignored (forced 0).
- o_imem_addr  out  32  combinational address to `i_mem.i_addr`.
- i_imem_data  in  32  `i_mem.o_data`; the word for the address presented last cycle.
- o_instr  out  32  IF/ID instruction.
- o_pc  out  32  IF/ID PC of o_instr.
- o_pc_four  out  32  o_pc + 4, registered with o_pc.
- o_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- State:
  - fetch_pc_q (32): address whose data is on i_imem_data this cycle.
  - primed_q (1): i_imem_data is meaningful.
  - IF/ID regs.
- Reset (i_reset=0 at edge):
  - fetch_pc_q<=RESET_VEC, primed_q<=0.
  - o_instr<=NOP_INSTR, o_pc<=RESET_VEC, o_pc_four<=RESET_VEC+4, o_valid<=0.
  - Reset dominates stall and redirect.
- o_imem_addr (combinational), priority order:
  - i_redirect → {i_redirect_pc[31:2],2'b00}
  - else !primed_q or i_stall → fetch_pc_q (re-read so data survives the hold)
  - else fetch_pc_q+4
- Address arithmetic: modulo 2^32; 0xFFFF_FFFC+4 = 0x0000_0000.
- fetch_pc_q<=o_imem_addr every non-reset cycle.
- primed_q<=1 every non-reset cycle.
- IF/ID update, priority order:
  1. i_redirect: o_instr<=NOP_INSTR, o_valid<=0; o_pc/o_pc_four don't-care but must be stable (hold).
  2. i_stall: hold all IF/ID outputs.
  3. !primed_q: o_instr<=NOP_INSTR, o_valid<=0.
  4. Otherwise: o_instr<=i_imem_data, o_pc<=fetch_pc_q, o_pc_four<=fetch_pc_q+4, o_valid<=1.
- Latency:
  - First valid instruction (pc=RESET_VEC) appears 2 cycles after reset release.
  - Steady state: 1 instruction per cycle.
  - Invariant while running: fetch_pc_q = o_pc+4.
- Redirect in cycle R:
  - o_valid=0 in R+1.
  - Target instruction visible in R+2.
  - Exactly one bubble.
- Simultaneous stall+redirect: redirect wins; stall is ignored that cycle.
- Redirect during !primed_q: treated as normal redirect.
- Stall asserted for N cycles: outputs frozen for N cycles, then sequence resumes with no skip or duplicate.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined:
  - Adds outputs o_fetch_cnt[31:0] and o_bubble_cnt[31:0], both reset to 0.
  - On each non-stall, non-reset edge: o_fetch_cnt++ if a valid instruction is latched; o_bubble_cnt++ if a bubble is latched (redirect or !primed_q).
  - Counters wrap at 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - localparam NOP_INSTR = 32'h0000_0013.
  - localparam ILEN = 32.
  - typedef struct packed {instr, pc, pc_four, valid} if_id_t, shared with decode.
- One sub-module: if_id_reg (IF/ID register with hold/flush/reset priority).
- PC select and prefetch logic stay in the top.

Test Plan:
1. Reset/startup: mem[4i]=0x1000_0000+i; i_reset=0 for 5 cycles then 1 → o_valid=0 in cycles 0,1 after release; cycle 2 o_pc=0x0, o_instr=0x1000_0000; cycle 3 o_pc=0x4, o_instr=0x1000_0001.
2. Stall: assert i_stall 3 cycles when o_pc=0x8 → o_pc=0x8 held 4 cycles total, o_imem_addr=0xC during stall; then o_pc=0xC, o_instr=0x1000_0003, no gap.
3. Redirect: i_redirect=1, i_redirect_pc=0x43 when o_pc=0x10 → o_imem_addr=0x40 that cycle; next cycle o_valid=0, o_instr=0x13; following cycle o_pc=0x40, o_instr=0x1000_0010, o_pc_four=0x44.
4. Stall+redirect same cycle (target 0x40) → identical response to scenario 3.
5. Wrap: RESET_VEC=0xFFFF_FFF8 → o_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with o_valid=1.
6. Reset mid-stall: i_reset=0 for 1 cycle while i_stall=1 → next cycle o_valid=0, o_instr=0x13, o_pc=RESET_VEC; restart timing as in scenario 1 (with IF_PERF_CNT_EN: counters read 0).
